// File: rtl/dynamic_limiter.sv
// Signed sample limiter with runtime threshold and shift-based attack/release AGC,
// four register levels from ready to done. Define LIMITER_STATS_EN to add clip_count.
module dynamic_limiter #(
    parameter int WIDTH           = 12,
    parameter int RELEASE_SAMPLES = 256,
    parameter int MAX_SHIFT       = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    ready,
    input  logic signed [WIDTH-1:0] incoming_sample,
    input  logic        [WIDTH-2:0] threshold,
    input  logic        [1:0]       limit_mode,
    output logic signed [WIDTH-1:0] modified_sample,
    output logic                    done,
    output logic        [2:0]       gain_shift
`ifdef LIMITER_STATS_EN
    ,
    output logic        [15:0]      clip_count
`endif
);

    localparam logic [2:0]       MAX_G   = 3'(MAX_SHIFT);
    localparam logic [16:0]      REL_LIM = 17'(RELEASE_SAMPLES);
    localparam logic [WIDTH-2:0] ONE_M   = {{(WIDTH-2){1'b0}}, 1'b1};
    localparam logic [WIDTH-2:0] MAX_M   = {(WIDTH-1){1'b1}};

    logic                    s1_valid_q;
    logic signed [WIDTH-1:0] s1_x_q;
    logic        [1:0]       s1_mode_q;
    logic        [WIDTH-2:0] s1_thr_q;

    logic                    s2_valid_q;
    logic signed [WIDTH-1:0] s2_x_q;
    logic        [1:0]       s2_mode_q;
    logic        [WIDTH-2:0] s2_thr_q;
    logic                    s2_neg_q;
    logic        [WIDTH-2:0] s2_mag_q;

    logic                    s3_valid_q;
    logic signed [WIDTH-1:0] s3_y_q;
    logic                    s3_clip_q;

    logic signed [WIDTH-1:0] modified_q;
    logic                    done_q;
    logic        [2:0]       gain_q, gain_d;
    logic        [15:0]      rel_cnt_q, rel_cnt_d;

    logic        [2:0]       g_eff_s;
    logic signed [WIDTH-1:0] a_s;
    logic        [WIDTH-2:0] mag_s;
    logic        [16:0]      rel_inc_s;

    logic        [WIDTH-2:0] knee_s;
    logic        [WIDTH-2:0] shaped_s;
    logic        [WIDTH-2:0] final_mag_s;
    logic                    clip_s;
    logic signed [WIDTH-1:0] y_s;

    assign modified_sample = modified_q;
    assign done            = done_q;
    assign gain_shift      = gain_q;

    // S1: capture sample together with the mode and threshold it must be judged by
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_mode_q  <= 2'b00;
            s1_thr_q   <= '0;
        end else begin
            s1_valid_q <= ready;
            if (ready) begin
                s1_x_q    <= incoming_sample;
                s1_mode_q <= limit_mode;
                s1_thr_q  <= threshold;
            end else begin
                s1_x_q    <= s1_x_q;
                s1_mode_q <= s1_mode_q;
                s1_thr_q  <= s1_thr_q;
            end
        end
    end

    // S2 datapath: attenuate by the current gain, saturating magnitude, gain/release update
    always_comb begin
        g_eff_s   = 3'd0;
        gain_d    = gain_q;
        rel_cnt_d = rel_cnt_q;
        if (s1_mode_q[1]) begin
            g_eff_s = gain_q;
        end else begin
            g_eff_s = 3'd0;
        end
        a_s = s1_x_q >>> g_eff_s;
        // Most-negative value has no positive twin; pin it to the largest magnitude
        if (a_s[WIDTH-1] && (a_s[WIDTH-2:0] == '0)) begin
            mag_s = MAX_M;
        end else if (a_s[WIDTH-1]) begin
            mag_s = ~a_s[WIDTH-2:0] + ONE_M;
        end else begin
            mag_s = a_s[WIDTH-2:0];
        end
        rel_inc_s = {1'b0, rel_cnt_q} + 17'd1;
        if (!s1_valid_q) begin
            gain_d    = gain_q;
            rel_cnt_d = rel_cnt_q;
        end else if (!s1_mode_q[1]) begin
            gain_d    = 3'd0;
            rel_cnt_d = 16'd0;
        end else if (mag_s > s1_thr_q) begin
            if (gain_q < MAX_G) begin
                gain_d = gain_q + 3'd1;
            end else begin
                gain_d = MAX_G;
            end
            rel_cnt_d = 16'd0;
        end else if (rel_inc_s >= REL_LIM) begin
            if (gain_q != 3'd0) begin
                gain_d    = gain_q - 3'd1;
                rel_cnt_d = 16'd0;
            end else begin
                gain_d    = gain_q;
                rel_cnt_d = REL_LIM[15:0];
            end
        end else begin
            rel_cnt_d = rel_inc_s[15:0];
        end
    end

    // S2 registers and the gain state that the next sample will see
    always_ff @(posedge clock) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            s2_x_q     <= '0;
            s2_mode_q  <= 2'b00;
            s2_thr_q   <= '0;
            s2_neg_q   <= 1'b0;
            s2_mag_q   <= '0;
            gain_q     <= 3'd0;
            rel_cnt_q  <= 16'd0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_x_q     <= s1_x_q;
            s2_mode_q  <= s1_mode_q;
            s2_thr_q   <= s1_thr_q;
            s2_neg_q   <= a_s[WIDTH-1];
            s2_mag_q   <= mag_s;
            gain_q     <= gain_d;
            rel_cnt_q  <= rel_cnt_d;
        end
    end

    // S3 datapath: optional soft knee, final clamp, sign restore
    always_comb begin
        knee_s      = s2_thr_q + ((s2_mag_q - s2_thr_q) >> 1'b1);
        shaped_s    = s2_mag_q;
        final_mag_s = s2_mag_q;
        clip_s      = 1'b0;
        y_s         = s2_x_q;
        case (s2_mode_q)
            2'b11: begin
                if (s2_mag_q > s2_thr_q) begin
                    shaped_s = knee_s;
                end else begin
                    shaped_s = s2_mag_q;
                end
            end
            default: shaped_s = s2_mag_q;
        endcase
        if (shaped_s > s2_thr_q) begin
            clip_s      = 1'b1;
            final_mag_s = s2_thr_q;
        end else begin
            clip_s      = 1'b0;
            final_mag_s = shaped_s;
        end
        if (s2_mode_q == 2'b00) begin
            clip_s = 1'b0;
            y_s    = s2_x_q;
        end else if (s2_neg_q) begin
            y_s = -{1'b0, final_mag_s};
        end else begin
            y_s = {1'b0, final_mag_s};
        end
    end

    // S3 registers
    always_ff @(posedge clock) begin
        if (reset) begin
            s3_valid_q <= 1'b0;
            s3_y_q     <= '0;
            s3_clip_q  <= 1'b0;
        end else begin
            s3_valid_q <= s2_valid_q;
            s3_y_q     <= y_s;
            s3_clip_q  <= clip_s & s2_valid_q;
        end
    end

    // Output register: result held until the next done
    always_ff @(posedge clock) begin
        if (reset) begin
            modified_q <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= s3_valid_q;
            if (s3_valid_q) begin
                modified_q <= s3_y_q;
            end else begin
                modified_q <= modified_q;
            end
        end
    end

`ifdef LIMITER_STATS_EN
    logic [15:0] clip_cnt_q;

    assign clip_count = clip_cnt_q;

    // Saturating count of samples altered by the final clamp
    always_ff @(posedge clock) begin
        if (reset) begin
            clip_cnt_q <= 16'd0;
        end else if (s3_valid_q && s3_clip_q && (clip_cnt_q != 16'hFFFF)) begin
            clip_cnt_q <= clip_cnt_q + 16'd1;
        end else begin
            clip_cnt_q <= clip_cnt_q;
        end
    end
`endif

endmodule

// File: tb/tb_dynamic_limiter.sv
// Directed self-checking bench for dynamic_limiter (WIDTH=12, RELEASE_SAMPLES=4, MAX_SHIFT=3).
module tb_dynamic_limiter;

    logic               clock = 1'b0;
    logic               reset;
    logic               ready;
    logic signed [11:0] incoming_sample;
    logic        [10:0] threshold;
    logic        [1:0]  limit_mode;
    logic signed [11:0] modified_sample;
    logic               done;
    logic        [2:0]  gain_shift;
`ifdef LIMITER_STATS_EN
    logic        [15:0] clip_count;
`endif

    int total = 0;
    int bad   = 0;

    dynamic_limiter #(
        .WIDTH(12),
        .RELEASE_SAMPLES(4),
        .MAX_SHIFT(3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ready(ready),
        .incoming_sample(incoming_sample),
        .threshold(threshold),
        .limit_mode(limit_mode),
        .modified_sample(modified_sample),
        .done(done),
        .gain_shift(gain_shift)
`ifdef LIMITER_STATS_EN
        ,
        .clip_count(clip_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One ready pulse; checks done is late enough, then exactly on time, plus y and gain.
    task automatic sample(input string tag, input int x, input logic [1:0] m, input int t,
                          input int exp_y, input int exp_g);
        @(negedge clock);
        ready           = 1'b1;
        incoming_sample = 12'(x);
        limit_mode      = m;
        threshold       = 11'(t);
        @(negedge clock);
        ready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk({tag, ".early"}, done, 0);
        @(negedge clock);
        chk({tag, ".done"}, done, 1);
        chk({tag, ".y"}, modified_sample, exp_y);
        chk({tag, ".g"}, gain_shift, exp_g);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset           = 1'b1;
        ready           = 1'b0;
        incoming_sample = 12'sd0;
        threshold       = 11'd0;
        limit_mode      = 2'b00;

        // 1: ready during reset is ignored
        @(negedge clock);
        ready           = 1'b1;
        incoming_sample = 12'sd500;
        limit_mode      = 2'b00;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk("rst.done", done, 0);
        end
        chk("rst.y", modified_sample, 0);
        chk("rst.g", gain_shift, 0);
        ready = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        chk("rst.after", done, 0);

        // 2: bypass, full-scale values and back-to-back
        sample("byp_pos", 2047, 2'b00, 0, 2047, 0);
        sample("byp_neg", -2048, 2'b00, 0, -2048, 0);
        @(negedge clock);
        ready = 1'b1; incoming_sample = 12'sd100; limit_mode = 2'b00;
        @(negedge clock);
        incoming_sample = -12'sd100;
        @(negedge clock);
        ready = 1'b0;
        @(negedge clock);
        chk("b2b.early", done, 0);
        @(negedge clock);
        chk("b2b.done0", done, 1);
        chk("b2b.y0", modified_sample, 100);
        @(negedge clock);
        chk("b2b.done1", done, 1);
        chk("b2b.y1", modified_sample, -100);
        @(negedge clock);
        chk("b2b.end", done, 0);
        chk("b2b.hold", modified_sample, -100);

        // 3: hard clip
        sample("clip_a", 1500, 2'b01, 1000, 1000, 0);
        sample("clip_b", -2048, 2'b01, 1000, -1000, 0);
        sample("clip_c", 500, 2'b01, 1000, 500, 0);
        sample("clip_d", -1000, 2'b01, 1000, -1000, 0);
        sample("thr0", -7, 2'b01, 0, 0, 0);
        sample("thr0_byp", 5, 2'b00, 0, 5, 0);

        // 4: attack then release after 4 quiet samples
        sample("agc_atk", 1500, 2'b10, 1000, 1000, 1);
        sample("agc_r1", 1500, 2'b10, 1000, 750, 1);
        sample("agc_r2", 1500, 2'b10, 1000, 750, 1);
        sample("agc_r3", 1500, 2'b10, 1000, 750, 1);
        sample("agc_r4", 1500, 2'b10, 1000, 750, 0);
        sample("agc_again", 1500, 2'b10, 1000, 1000, 1);

        // 5: gain saturates at MAX_SHIFT; knee result still clamped
        sample("g_clr", 0, 2'b01, 100, 0, 0);
        sample("sat1", 2047, 2'b10, 100, 100, 1);
        sample("sat2", 2047, 2'b10, 100, 100, 2);
        sample("sat3", 2047, 2'b10, 100, 100, 3);
        sample("sat4", 2047, 2'b10, 100, 100, 3);
        sample("sat_neg", -2048, 2'b10, 100, -100, 3);
        sample("agc_thr0", 5, 2'b10, 0, 0, 3);
        sample("g_clr2", 0, 2'b01, 1000, 0, 0);
        sample("knee", 1600, 2'b11, 1000, 1000, 1);
        sample("knee_next", 1600, 2'b11, 1000, 800, 1);

        // 6: reset discards in-flight sample and gain state
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        sample("cc_a", 1500, 2'b01, 1000, 1000, 0);
        sample("cc_b", -1500, 2'b01, 1000, -1000, 0);
        sample("cc_c", 300, 2'b01, 1000, 300, 0);
        sample("cc_d", 2047, 2'b01, 1000, 1000, 0);
`ifdef LIMITER_STATS_EN
        chk("clip_count3", clip_count, 3);
`endif
        sample("pre_rst", 1500, 2'b10, 1000, 1000, 1);
        @(negedge clock);
        ready = 1'b1; incoming_sample = 12'sd1500; limit_mode = 2'b10; threshold = 11'd1000;
        @(negedge clock);
        ready = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("mid_rst.done", done, 0);
        end
        chk("mid_rst.g", gain_shift, 0);
        chk("mid_rst.y", modified_sample, 0);
`ifdef LIMITER_STATS_EN
        chk("clip_count_rst", clip_count, 0);
`endif
        sample("recover", -1500, 2'b01, 1000, -1000, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
